// File: rtl/regport_pkg.sv
//------------------------------------------------------------------------------
// regport_pkg: shared widths, op codes, FSM encoding and lane-mask helper for
// the register-file port master.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package regport_pkg;

  localparam int LANE_W = 8;
  localparam int IDX_W  = 5;
  localparam int DATA_W = 2 * LANE_W;
  localparam int ADDR_W = 2 * IDX_W;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_COPY  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  function automatic logic [DATA_W-1:0] lane_mask(input logic [1:0] en);
    return {{LANE_W{en[1]}}, {LANE_W{en[0]}}};
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_port_master.sv
//------------------------------------------------------------------------------
// regfile_port_master: sequences READ/WRITE/COPY requests onto the dual-lane
// 32x8 register file. Optional macro REGPORT_R0_PROTECT_EN makes index 0 read-only.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_port_master
  import regport_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [1:0]        req_byte_en,
  input  logic [ADDR_W-1:0] req_src_addr,
  input  logic [ADDR_W-1:0] req_dst_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [1:0]        rf_wr_en,
  output logic [1:0]        rf_rd_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_op;
  logic [1:0]        r_be;
  logic [1:0]        r_wr_mask;
  logic [ADDR_W-1:0] r_dst;
  logic [DATA_W-1:0] r_data;
  logic              r_err;

  logic              w_accept;
  logic [1:0]        w_req_mask;
  logic [DATA_W-1:0] w_capture;
  logic [1:0]        w_rd_en;
  logic [1:0]        w_wr_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wdata;

  assign w_accept  = req_valid && req_ready;
  assign w_capture = rf_rdata & lane_mask(r_be);

  // Lanes actually written once index-0 protection (if built in) is applied.
`ifdef REGPORT_R0_PROTECT_EN
  assign w_req_mask = req_byte_en & {(req_dst_addr[2*IDX_W-1:IDX_W] != '0),
                                     (req_dst_addr[IDX_W-1:0] != '0)};
`else
  assign w_req_mask = req_byte_en;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (req_byte_en == 2'b00)    w_next = ST_RESP;
          else if (req_op == OP_WRITE) w_next = ST_WR;
          else                         w_next = ST_RD;
        end
      end
      ST_RD:   w_next = (r_op == OP_COPY) ? ST_WR : ST_RESP;
      ST_WR:   w_next = ST_RESP;
      ST_RESP: if (rsp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Next values of the registered pins: only the state being entered drives them.
  always_comb begin
    req_ready = (r_state == ST_IDLE);
    rsp_valid = (r_state == ST_RESP);
    w_rd_en   = 2'b00;
    w_rd_addr = '0;
    w_wr_en   = 2'b00;
    w_wr_addr = '0;
    w_wdata   = '0;
    if (r_state == ST_IDLE && w_next == ST_RD) begin
      w_rd_en   = req_byte_en;
      w_rd_addr = req_src_addr;
    end
    if (r_state == ST_IDLE && w_next == ST_WR) begin
      w_wr_en   = w_req_mask;
      w_wr_addr = req_dst_addr;
      w_wdata   = req_wdata;
    end
    if (r_state == ST_RD && w_next == ST_WR) begin
      w_wr_en   = r_wr_mask;
      w_wr_addr = r_dst;
      w_wdata   = w_capture;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op       <= OP_READ;
      r_be       <= 2'b00;
      r_wr_mask  <= 2'b00;
      r_dst      <= '0;
      r_data     <= '0;
      r_err      <= 1'b0;
      rf_rd_en   <= 2'b00;
      rf_rd_addr <= '0;
      rf_wr_en   <= 2'b00;
      rf_wr_addr <= '0;
      rf_wdata   <= '0;
    end else begin
      rf_rd_en   <= w_rd_en;
      rf_rd_addr <= w_rd_addr;
      rf_wr_en   <= w_wr_en;
      rf_wr_addr <= w_wr_addr;
      rf_wdata   <= w_wdata;
      if (w_accept) begin
        r_op      <= req_op;
        r_be      <= req_byte_en;
        r_wr_mask <= w_req_mask;
        r_dst     <= req_dst_addr;
        r_data    <= (req_op == OP_WRITE) ? (req_wdata & lane_mask(w_req_mask)) : '0;
        r_err     <= ((req_op == OP_WRITE) || (req_op == OP_COPY)) &&
                     ((req_byte_en & ~w_req_mask) != 2'b00);
      end else if (r_state == ST_RD) begin
        r_data <= w_capture;
      end
    end
  end

  assign rsp_data = r_data;
  assign rsp_err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_regfile_port_master.sv
//------------------------------------------------------------------------------
// tb_regfile_port_master: directed self-checking bench with a behavioural
// dual-lane register file. Honours REGPORT_R0_PROTECT_EN for expectations.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_port_master;
  import regport_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [1:0]  req_byte_en = 2'd0;
  logic [9:0]  req_src_addr = '0;
  logic [9:0]  req_dst_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [1:0]  rf_wr_en;
  logic [1:0]  rf_rd_en;
  logic [9:0]  rf_wr_addr;
  logic [9:0]  rf_rd_addr;
  logic [15:0] rf_wdata;
  logic [15:0] rf_rdata = '0;

  logic [7:0]  mem_lo [32];
  logic [7:0]  mem_hi [32];
  int          checks = 0;
  int          failures = 0;

  regfile_port_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_byte_en(req_byte_en), .req_src_addr(req_src_addr),
    .req_dst_addr(req_dst_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
    .rf_wr_addr(rf_wr_addr), .rf_rd_addr(rf_rd_addr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata)
  );

  always #5 clock = ~clock;

  // Register file model: read on falling edge, commit on rising edge.
  always @(negedge clock) begin
    rf_rdata[7:0]  <= rf_rd_en[0] ? mem_lo[rf_rd_addr[4:0]] : 8'hA5;
    rf_rdata[15:8] <= rf_rd_en[1] ? mem_hi[rf_rd_addr[9:5]] : 8'hA5;
  end

  always @(posedge clock) begin
    if (!reset) begin
      if (rf_wr_en[0]) mem_lo[rf_wr_addr[4:0]] <= rf_wdata[7:0];
      if (rf_wr_en[1]) mem_hi[rf_wr_addr[9:5]] <= rf_wdata[15:8];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] op, input logic [1:0] be,
                           input logic [9:0] src, input logic [9:0] dst,
                           input logic [15:0] wd);
    req_valid = 1'b1; req_op = op; req_byte_en = be;
    req_src_addr = src; req_dst_addr = dst; req_wdata = wd;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({rsp_valid, rsp_data, rsp_err, rf_wr_en, rf_rd_en, rf_wr_addr, rf_rd_addr, rf_wdata} !== '0) begin
      $display("FAIL reset_outputs got rsp_valid=%b rsp_data=%h rf_wr_en=%b rf_rd_en=%b required all 0",
               rsp_valid, rsp_data, rf_wr_en, rf_rd_en);
      failures++;
    end
    tick(); tick();
    reset = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      $display("FAIL reset_release got req_ready=%b rsp_valid=%b required 1/0", req_ready, rsp_valid);
      failures++;
    end
  endtask

  task automatic test_write();
    drive_req(OP_WRITE, 2'b11, 10'h000, 10'h0A3, 16'hBEEF);
    tick();
    req_valid = 1'b0;
    checks++;
    if (rf_wr_en !== 2'b11 || rf_wr_addr !== 10'h0A3 || rf_wdata !== 16'hBEEF || rf_rd_en !== 2'b00) begin
      $display("FAIL write_pins got wr_en=%b addr=%h wdata=%h rd_en=%b required 11/0a3/beef/00",
               rf_wr_en, rf_wr_addr, rf_wdata, rf_rd_en);
      failures++;
    end
    checks++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
      $display("FAIL write_busy got req_ready=%b rsp_valid=%b required 0/0", req_ready, rsp_valid);
      failures++;
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || rsp_err !== 1'b0 || rf_wr_en !== 2'b00) begin
      $display("FAIL write_rsp got valid=%b data=%h err=%b wr_en=%b required 1/beef/0/00",
               rsp_valid, rsp_data, rsp_err, rf_wr_en);
      failures++;
    end
    handshake();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_lo[3] !== 8'hEF || mem_hi[5] !== 8'hBE) begin
      $display("FAIL write_done got req_ready=%b rsp_valid=%b lo3=%h hi5=%h required 1/0/ef/be",
               req_ready, rsp_valid, mem_lo[3], mem_hi[5]);
      failures++;
    end
  endtask

  task automatic test_read();
    drive_req(OP_READ, 2'b01, 10'h0A3, 10'h3FF, 16'hFFFF);
    tick();
    req_valid = 1'b0;
    checks++;
    if (rf_rd_en !== 2'b01 || rf_rd_addr !== 10'h0A3 || rf_wr_en !== 2'b00) begin
      $display("FAIL read_pins got rd_en=%b addr=%h wr_en=%b required 01/0a3/00", rf_rd_en, rf_rd_addr, rf_wr_en);
      failures++;
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h00EF || rf_rd_en !== 2'b00) begin
      $display("FAIL read_rsp got valid=%b data=%h rd_en=%b required 1/00ef/00", rsp_valid, rsp_data, rf_rd_en);
      failures++;
    end
    handshake();
  endtask

  task automatic test_copy();
    drive_req(OP_COPY, 2'b11, 10'h0A3, {5'd9, 5'd7}, 16'h0000);
    tick();
    req_valid = 1'b0;
    checks++;
    if (rf_rd_en !== 2'b11 || rf_rd_addr !== 10'h0A3 || rf_wr_en !== 2'b00) begin
      $display("FAIL copy_rd got rd_en=%b addr=%h wr_en=%b required 11/0a3/00", rf_rd_en, rf_rd_addr, rf_wr_en);
      failures++;
    end
    tick();
    checks++;
    if (rf_wr_en !== 2'b11 || rf_wr_addr !== {5'd9, 5'd7} || rf_wdata !== 16'hBEEF ||
        rf_rd_en !== 2'b00 || rsp_valid !== 1'b0) begin
      $display("FAIL copy_wr got wr_en=%b addr=%h wdata=%h rd_en=%b valid=%b required 11/127/beef/00/0",
               rf_wr_en, rf_wr_addr, rf_wdata, rf_rd_en, rsp_valid);
      failures++;
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'hBEEF || rsp_err !== 1'b0) begin
      $display("FAIL copy_rsp got valid=%b data=%h err=%b required 1/beef/0", rsp_valid, rsp_data, rsp_err);
      failures++;
    end
    handshake();
    checks++;
    if (mem_lo[7] !== 8'hEF || mem_hi[9] !== 8'hBE) begin
      $display("FAIL copy_mem got lo7=%h hi9=%h required ef/be", mem_lo[7], mem_hi[9]);
      failures++;
    end
  endtask

  task automatic test_stall();
    drive_req(OP_READ, 2'b10, {5'd5, 5'd0}, 10'h000, 16'h0000);
    tick();
    req_valid = 1'b0;
    tick();
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 16'hBE00 || req_ready !== 1'b0 ||
          rf_rd_en !== 2'b00 || rf_wr_en !== 2'b00) begin
        $display("FAIL stall_%0d got valid=%b data=%h req_ready=%b rd_en=%b wr_en=%b required 1/be00/0/00/00",
                 i, rsp_valid, rsp_data, req_ready, rf_rd_en, rf_wr_en);
        failures++;
      end
      tick();
    end
    req_valid = 1'b0;
    handshake();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      $display("FAIL stall_release got req_ready=%b valid=%b required 1/0", req_ready, rsp_valid);
      failures++;
    end
  endtask

  task automatic test_byte_en_zero();
    drive_req(OP_WRITE, 2'b00, 10'h000, 10'h0A3, 16'h1234);
    tick();
    req_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 16'h0000 || rf_wr_en !== 2'b00 || rf_rd_en !== 2'b00) begin
      $display("FAIL be0_rsp got valid=%b data=%h wr_en=%b rd_en=%b required 1/0000/00/00",
               rsp_valid, rsp_data, rf_wr_en, rf_rd_en);
      failures++;
    end
    handshake();
  endtask

  task automatic test_protect();
    logic [1:0]  exp_en;
    logic        exp_err;
    logic [15:0] exp_data;
`ifdef REGPORT_R0_PROTECT_EN
    exp_en = 2'b10; exp_err = 1'b1; exp_data = 16'h1200;
`else
    exp_en = 2'b11; exp_err = 1'b0; exp_data = 16'h1234;
`endif
    drive_req(OP_WRITE, 2'b11, 10'h000, {5'd4, 5'd0}, 16'h1234);
    tick();
    req_valid = 1'b0;
    checks++;
    if (rf_wr_en !== exp_en || rf_wr_addr !== {5'd4, 5'd0}) begin
      $display("FAIL protect_pins got wr_en=%b addr=%h required %b/080", rf_wr_en, rf_wr_addr, exp_en);
      failures++;
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== exp_err || rsp_data !== exp_data) begin
      $display("FAIL protect_rsp got valid=%b err=%b data=%h required 1/%b/%h",
               rsp_valid, rsp_err, rsp_data, exp_err, exp_data);
      failures++;
    end
    handshake();
  endtask

  task automatic test_reset_mid_resp();
    drive_req(OP_READ, 2'b11, 10'h0A3, 10'h000, 16'h0000);
    tick();
    req_valid = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 16'h0000 || rsp_err !== 1'b0 || rf_rd_en !== 2'b00) begin
      $display("FAIL reset_resp got valid=%b data=%h err=%b rd_en=%b required 0/0000/0/00",
               rsp_valid, rsp_data, rsp_err, rf_rd_en);
      failures++;
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      $display("FAIL reset_resp_release got req_ready=%b valid=%b required 1/0", req_ready, rsp_valid);
      failures++;
    end
  endtask

  task automatic test_reset_mid_wr();
    drive_req(OP_WRITE, 2'b11, 10'h000, {5'd6, 5'd6}, 16'h5A5A);
    tick();
    req_valid = 1'b0;
    checks++;
    if (rf_wr_en !== 2'b11) begin
      $display("FAIL reset_wr_pre got wr_en=%b required 11", rf_wr_en);
      failures++;
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (rf_wr_en !== 2'b00 || rf_wdata !== 16'h0000 || rf_wr_addr !== 10'h000) begin
      $display("FAIL reset_wr_drop got wr_en=%b wdata=%h addr=%h required 00/0000/000",
               rf_wr_en, rf_wdata, rf_wr_addr);
      failures++;
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      $display("FAIL reset_wr_release got req_ready=%b valid=%b required 1/0", req_ready, rsp_valid);
      failures++;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      mem_lo[i] = 8'h00;
      mem_hi[i] = 8'h00;
    end
    test_reset();
    test_write();
    test_read();
    test_copy();
    test_stall();
    test_byte_en_zero();
    test_protect();
    test_reset_mid_resp();
    test_reset_mid_wr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
